// File: rtl/reversi_accel_pkg.sv
// Shared constants for the reversi evaluation accelerator's multiplier datapath.
// Also holds the modulo-wrap helper used by the round-robin logic.
package reversi_accel_pkg;

  localparam int MUL_A_W = 16;
  localparam int MUL_B_W = 12;
  localparam int MUL_P_W = 28;
  localparam int MUL_LAT = 3;

  typedef logic [MUL_A_W-1:0] mul_a_t;
  typedef logic [MUL_B_W-1:0] mul_b_t;
  typedef logic [MUL_P_W-1:0] mul_p_t;

  // Wraps an index that is at most 2*n-1 back into 0..n-1 without a divider.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/reversi_mul_arbiter_if.sv
// Requester and result channels of the shared multiplier arbiter.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1;
// the producer may drop valid without a transfer, and ready may depend combinationally on valid.
interface reversi_mul_arbiter_if
  import reversi_accel_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*MUL_A_W-1:0] req_a;
  logic [NREQ*MUL_B_W-1:0] req_b;
  logic                    res_valid;
  logic                    res_ready;
  logic [IDW-1:0]          res_id;
  logic [MUL_P_W-1:0]      res_data;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_data
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_data
  );

endinterface

// File: rtl/reversi_accel_mul_mul_16ns_12s_28_4_1.sv
// Pipelined 16-bit unsigned x 12-bit signed multiplier, three ce-enabled register stages.
// Data registers are deliberately unreset; downstream qualifies dout with its own valid tags.
module reversi_accel_mul_mul_16ns_12s_28_4_1
  import reversi_accel_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  mul_a_t       din0,
  input  mul_b_t       din1,
  output mul_p_t       dout
);

  mul_a_t                    a_r;
  mul_b_t                    b_r;
  logic signed [MUL_P_W-1:0] a_ext;
  logic signed [MUL_P_W-1:0] b_ext;
  logic signed [MUL_P_W-1:0] prod;
  mul_p_t                    p_r;
  mul_p_t                    dout_r;
  logic                      unused_reset;

  assign unused_reset = reset;

  // A is zero-extended (unsigned), B sign-extended; the true product fits in 28 bits.
  assign a_ext = {{(MUL_P_W-MUL_A_W){1'b0}}, a_r};
  assign b_ext = {{(MUL_P_W-MUL_B_W){b_r[MUL_B_W-1]}}, b_r};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk) begin
    if (ce) begin
      a_r    <= din0;
      b_r    <= din1;
      p_r    <= prod;
      dout_r <= p_r;
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/reversi_rr_arbiter.sv
// Round-robin grant over NREQ requesters: search starts at rr_ptr, pointer moves past
// the winner after each completed handshake.
module reversi_rr_arbiter
  import reversi_accel_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any,
  output logic [IDW-1:0]  rr_ptr
);

  logic [IDW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'(rr_wrap(int'(rr_ptr) + k, NREQ));
      if (en && !grant_any && req_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

  // A grant is only ever issued to a valid requester, so grant_any marks a handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= IDW'(rr_wrap(int'(grant_idx) + 1, NREQ));
    end
  end

endmodule

// File: rtl/reversi_mul_arbiter.sv
// Shares one pipelined multiplier among NREQ requesters; a {valid,id} tag pipe runs
// beside the multiplier and the whole pipe freezes while the result channel is stalled.
module reversi_mul_arbiter
  import reversi_accel_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  reversi_mul_arbiter_if.slave  bus,
  output logic [IDW-1:0]        dbg_rr_ptr
);

  logic            stall;
  logic            ce;
  logic            arb_en;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  mul_a_t          din0;
  mul_b_t          din1;
  mul_p_t          dout;
  logic [MUL_LAT-1:0] tag_v;
  logic [IDW-1:0]     tag_id [MUL_LAT];

  assign stall  = tag_v[MUL_LAT-1] & ~bus.res_ready;
  assign ce     = ~stall;
  // No grants while reset is asserted, so req_ready reads 0 during reset.
  assign arb_en = ce & reset_n;

  reversi_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (arb_en),
    .req_valid (bus.req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any),
    .rr_ptr    (dbg_rr_ptr)
  );

  assign bus.req_ready = grant;

  always_comb begin
    din0 = '0;
    din1 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        din0 = bus.req_a[MUL_A_W*i +: MUL_A_W];
        din1 = bus.req_b[MUL_B_W*i +: MUL_B_W];
      end
    end
  end

  reversi_accel_mul_mul_16ns_12s_28_4_1 u_mul (
    .clk   (clk),
    .reset (~reset_n),
    .ce    (ce),
    .din0  (din0),
    .din1  (din1),
    .dout  (dout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        tag_id[s] <= '0;
      end
    end else if (ce) begin
      tag_v     <= {tag_v[MUL_LAT-2:0], grant_any};
      tag_id[0] <= grant_idx;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  assign bus.res_valid = tag_v[MUL_LAT-1];
  assign bus.res_id    = tag_id[MUL_LAT-1];
  assign bus.res_data  = dout;

endmodule

// File: tb/tb_reversi_mul_arbiter.sv
// Bench for reversi_mul_arbiter: in-flight latency model checked every cycle plus
// directed scenarios with hand-computed grants, ids and products.
module tb_reversi_mul_arbiter;
  import reversi_accel_pkg::*;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int CLK_P = 10;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [IDW-1:0] dbg_rr_ptr;

  reversi_mul_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  reversi_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- clock / reset ----------------
  always #(CLK_P/2) clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [IDW+MUL_P_W-1:0] exp_q[$];
  int                     due_q[$];
  int                     m_ptr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [MUL_P_W-1:0] p28(input int v);
    return v[MUL_P_W-1:0];
  endfunction

  function automatic logic [MUL_P_W-1:0] prod(input logic [15:0] a, input logic [11:0] b);
    return p28(int'(a) * int'($signed(b)));
  endfunction

  // Each accepted op must appear after two further non-stalled edges, in issue order.
  always @(negedge clk) begin
    logic           m_valid;
    logic           m_stall;
    logic [NREQ-1:0] g;
    int             gi;
    if (!reset_n) begin
      exp_q.delete();
      due_q.delete();
      m_ptr = 0;
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_req_ready", bus.req_ready, 0);
    end else begin
      m_valid = (due_q.size() > 0) && (due_q[0] == 0);
      check("res_valid", bus.res_valid, m_valid);
      if (m_valid) begin
        check("res_id", bus.res_id, exp_q[0][IDW+MUL_P_W-1:MUL_P_W]);
        check("res_data", bus.res_data, exp_q[0][MUL_P_W-1:0]);
      end
      m_stall = m_valid && !bus.res_ready;
      g  = '0;
      gi = -1;
      if (!m_stall) begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (gi < 0 && bus.req_valid[c]) begin
            gi   = c;
            g[c] = 1'b1;
          end
        end
      end
      check("req_ready", bus.req_ready, g);
      if (!m_stall) begin
        if (m_valid) begin
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
        foreach (due_q[i]) if (due_q[i] > 0) due_q[i]--;
        if (gi >= 0) begin
          exp_q.push_back({IDW'(gi), prod(bus.req_a[16*gi +: 16], bus.req_b[12*gi +: 12])});
          due_q.push_back(2);
          m_ptr = (gi + 1) % NREQ;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [15:0] a, input logic [11:0] b);
    bus.req_a[16*i +: 16] = a;
    bus.req_b[12*i +: 12] = b;
    bus.req_valid[i]      = 1'b1;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    next_edge();
    reset_n       = 1'b0;
    bus.req_valid = '0;
    next_edge();
    reset_n = 1'b1;
  endtask

  // Counts negedges until res_valid, bounded.
  task automatic wait_res(input string name, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.res_valid && lat < 20);
    check({name, "_seen"}, bus.res_valid, 1);
  endtask

  // ---------------- directed stimulus ----------------
  logic [3:0] t2_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int         t2_ids   [5] = '{0, 1, 2, 3, 0};
  logic [3:0] t6_grant [6] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};

  initial begin
    int lat;
    int got_id[$];
    int got_k[$];
    logic [MUL_P_W-1:0] got_data[$];
    logic [MUL_P_W-1:0] frozen;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    reset_n       = 1'b1;
    #2 reset_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    @(negedge clk);
    check("reset_res_valid", bus.res_valid, 0);
    check("reset_res_id", bus.res_id, 0);
    check("reset_rr_ptr", dbg_rr_ptr, 0);

    // 1: single op, latency and signed product
    next_edge();
    set_req(0, 16'd100, -12'sd3);
    @(negedge clk);
    check("t1_grant", bus.req_ready, 4'b0001);
    next_edge();
    bus.req_valid = '0;
    wait_res("t1", lat);
    check("t1_latency", lat, 3);
    check("t1_id", bus.res_id, 0);
    check("t1_data", bus.res_data, p28(-300));
    @(negedge clk);
    check("t1_single", bus.res_valid, 0);

    // 2: all requesters held from rr_ptr=0
    pulse_reset();
    set_req(0, 16'd1000, -12'sd5);
    set_req(1, 16'd1111, 12'sd7);
    set_req(2, 16'd1222, -12'sd2048);
    set_req(3, 16'd1333, 12'sd2047);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k < 5) check("t2_grant", bus.req_ready, t2_grant[k]);
      if (bus.res_valid) begin
        got_id.push_back(int'(bus.res_id));
        got_k.push_back(k);
        got_data.push_back(bus.res_data);
      end
      if (k == 4) begin
        next_edge();
        bus.req_valid = '0;
      end
    end
    check("t2_count", got_id.size(), 5);
    if (got_id.size() == 5) begin
      for (int k = 0; k < 5; k++) check("t2_order", got_id[k], t2_ids[k]);
      check("t2_back_to_back", got_k[4] - got_k[0], 4);
      check("t2_data0", got_data[0], p28(-5000));
      check("t2_data2", got_data[2], p28(-2502656));
      check("t2_data4", got_data[4], p28(-5000));
    end

    // 3: extreme operands
    next_edge();
    set_req(2, 16'd65535, -12'sd2048);
    next_edge();
    bus.req_valid = '0;
    wait_res("t3a", lat);
    check("t3a_id", bus.res_id, 2);
    check("t3a_data", bus.res_data, p28(-134215680));
    next_edge();
    set_req(3, 16'd65535, 12'sd2047);
    next_edge();
    bus.req_valid = '0;
    wait_res("t3b", lat);
    check("t3b_id", bus.res_id, 3);
    check("t3b_data", bus.res_data, p28(134150145));

    // 4: stall with three ops in flight (rr_ptr is 0 here)
    next_edge();
    set_req(0, 16'd3, 12'sd5);
    set_req(1, 16'd200, -12'sd7);
    set_req(2, 16'd4096, -12'sd1);
    next_edge();
    next_edge();
    next_edge();
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b0;
    frozen = p28(15);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_hold_valid", bus.res_valid, 1);
      check("t4_hold_id", bus.res_id, 0);
      check("t4_hold_data", bus.res_data, frozen);
      check("t4_no_grant", bus.req_ready, 0);
    end
    next_edge();
    bus.res_ready = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    check("t4_r0_id", bus.res_id, 0);
    check("t4_r0_data", bus.res_data, p28(15));
    @(negedge clk);
    check("t4_r1_id", bus.res_id, 1);
    check("t4_r1_data", bus.res_data, p28(-1400));
    @(negedge clk);
    check("t4_r2_id", bus.res_id, 2);
    check("t4_r2_data", bus.res_data, p28(-4096));
    @(negedge clk);
    check("t4_drained", bus.res_valid, 0);

    // 5: reset with two ops in flight
    next_edge();
    set_req(0, 16'd9, 12'sd9);
    set_req(1, 16'd8, 12'sd8);
    next_edge();
    next_edge();
    bus.req_valid = '0;
    reset_n       = 1'b0;
    next_edge();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_no_res", bus.res_valid, 0);
    end
    check("t5_rr_ptr", dbg_rr_ptr, 0);

    // 6: req1 and req3 alternate once rr_ptr=2
    next_edge();
    set_req(1, 16'd7, -12'sd1);
    @(negedge clk);
    check("t6_setup_grant", bus.req_ready, 4'b0010);
    next_edge();
    bus.req_valid = '0;
    @(negedge clk);
    check("t6_rr_ptr", dbg_rr_ptr, 2);
    next_edge();
    set_req(1, 16'd21, 12'sd3);
    set_req(3, 16'd40, -12'sd10);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t6_grant", bus.req_ready, t6_grant[k]);
    end
    next_edge();
    bus.req_valid = '0;
    repeat (6) @(negedge clk);
    check("t6_drained", bus.res_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
